// File: rtl/gen_rr_mux_n.sv
// N-channel valid/ready multiplexer with round-robin or fixed-priority arbitration
// and a single registered output stage. Define GEN_MUX_LOCK_EN to add grant locking.
module gen_rr_mux_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_CH-1:0]            mux_valid_in,
  output logic [NUM_CH-1:0]            mux_ready_out,
  input  logic [NUM_CH*DATA_WIDTH-1:0] mux_data_in,
  output logic                         mux_valid_out,
  input  logic                         mux_ready_in,
  output logic [DATA_WIDTH-1:0]        mux_data_out,
  output logic [SEL_WIDTH-1:0]         mux_sel_out
`ifdef GEN_MUX_LOCK_EN
  ,
  input  logic                         mux_lock_in
`endif
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [SEL_WIDTH-1:0]  r_ptr;
`ifdef GEN_MUX_LOCK_EN
  logic                  r_lock;
  logic [SEL_WIDTH-1:0]  r_lock_ch;
`endif

  logic [NUM_CH-1:0]     w_req;
  logic                  w_gnt_vld;
  logic [SEL_WIDTH-1:0]  w_gnt_idx;
  logic [SEL_WIDTH-1:0]  w_cand;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic [SEL_WIDTH-1:0]  w_ptr_nxt;
  logic                  w_accept;
  logic                  w_xfer;
  int                    w_pos;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_req     = mux_valid_in;
`ifdef GEN_MUX_LOCK_EN
    if (r_lock) w_req = mux_valid_in & (NUM_CH'(1) << r_lock_ch);
`endif
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_pos     = 0;
    // Walk the search order backwards so the earliest candidate is the last write.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_pos = (ARB_MODE == 0) ? int'(r_ptr) + k : k;
      if (w_pos >= NUM_CH) w_pos = w_pos - NUM_CH;
      w_cand = SEL_WIDTH'(w_pos);
      if (w_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_gnt_idx == SEL_WIDTH'(k)) w_gnt_data = mux_data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_accept      = !r_valid || mux_ready_in;
  assign w_xfer        = w_gnt_vld && w_accept && !rst_in;
  assign mux_ready_out = w_xfer ? (NUM_CH'(1) << w_gnt_idx) : '0;
  // Explicit wrap so a non-power-of-two channel count never points at an unused index.
  assign w_ptr_nxt     = (w_gnt_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
`ifdef GEN_MUX_LOCK_EN
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
`endif
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_sel   <= w_gnt_idx;
`ifdef GEN_MUX_LOCK_EN
      if (mux_lock_in) begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_gnt_idx;
      end else begin
        r_lock <= 1'b0;
        r_ptr  <= w_ptr_nxt;
      end
`else
      r_ptr   <= w_ptr_nxt;
`endif
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  assign mux_valid_out = r_valid;
  assign mux_data_out  = r_data;
  assign mux_sel_out   = r_sel;

endmodule

// File: tb/tb_gen_rr_mux_n.sv
// Bench for gen_rr_mux_n: three instances (4-ch round-robin, 4-ch fixed priority,
// 3-ch round-robin) checked every cycle against a behavioural arbitration model.
module tb_gen_rr_mux_n;

`ifdef GEN_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam int M_N    [3] = '{4, 4, 3};
  localparam int M_MODE [3] = '{0, 1, 0};

  logic         clk = 1'b0;
  logic         rst;
  logic         lock_in;
  logic [3:0]   vin    [3];
  logic [127:0] din    [3];
  logic         rdy_in [3];

  logic [3:0]  rout0, rout1;
  logic [2:0]  rout2;
  logic        vout0, vout1, vout2;
  logic [31:0] dout0, dout1, dout2;
  logic [1:0]  sout0, sout1, sout2;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_ptr  [3];
  bit          m_vld  [3];
  logic [31:0] m_data [3];
  int          m_sel  [3];
  bit          m_lock [3];
  int          m_lch  [3];

  always #5 clk = ~clk;

  gen_rr_mux_n #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(0)) u_rr4 (
    .clk_in(clk), .rst_in(rst), .mux_valid_in(vin[0]), .mux_ready_out(rout0),
    .mux_data_in(din[0]), .mux_valid_out(vout0), .mux_ready_in(rdy_in[0]),
    .mux_data_out(dout0), .mux_sel_out(sout0)
`ifdef GEN_MUX_LOCK_EN
    , .mux_lock_in(lock_in)
`endif
  );

  gen_rr_mux_n #(.DATA_WIDTH(32), .NUM_CH(4), .SEL_WIDTH(2), .ARB_MODE(1)) u_fp4 (
    .clk_in(clk), .rst_in(rst), .mux_valid_in(vin[1]), .mux_ready_out(rout1),
    .mux_data_in(din[1]), .mux_valid_out(vout1), .mux_ready_in(rdy_in[1]),
    .mux_data_out(dout1), .mux_sel_out(sout1)
`ifdef GEN_MUX_LOCK_EN
    , .mux_lock_in(lock_in)
`endif
  );

  gen_rr_mux_n #(.DATA_WIDTH(32), .NUM_CH(3), .SEL_WIDTH(2), .ARB_MODE(0)) u_rr3 (
    .clk_in(clk), .rst_in(rst), .mux_valid_in(vin[2][2:0]), .mux_ready_out(rout2),
    .mux_data_in(din[2][95:0]), .mux_valid_out(vout2), .mux_ready_in(rdy_in[2]),
    .mux_data_out(dout2), .mux_sel_out(sout2)
`ifdef GEN_MUX_LOCK_EN
    , .mux_lock_in(lock_in)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_rout(int k);
    case (k)
      0:       return {28'd0, rout0};
      1:       return {28'd0, rout1};
      default: return {29'd0, rout2};
    endcase
  endfunction

  function automatic logic [31:0] get_vout(int k);
    case (k)
      0:       return {31'd0, vout0};
      1:       return {31'd0, vout1};
      default: return {31'd0, vout2};
    endcase
  endfunction

  function automatic logic [31:0] get_dout(int k);
    case (k)
      0:       return dout0;
      1:       return dout1;
      default: return dout2;
    endcase
  endfunction

  function automatic logic [31:0] get_sout(int k);
    case (k)
      0:       return {30'd0, sout0};
      1:       return {30'd0, sout1};
      default: return {30'd0, sout2};
    endcase
  endfunction

  // Channel the rules would grant: scan the search order, honouring any lock.
  function automatic int model_grant(int k);
    for (int j = 0; j < M_N[k]; j++) begin
      int c;
      c = (M_MODE[k] == 1) ? j : (m_ptr[k] + j) % M_N[k];
      if (vin[k][c] && (!m_lock[k] || c == m_lch[k])) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_vld[k] = 1'b0; m_data[k] = '0;
      m_sel[k] = 0; m_lock[k] = 1'b0; m_lch[k] = 0;
    end
  endtask

  // One clock: check ready at the falling edge, advance the model at the rising
  // edge, then check the registered outputs just after it.
  task automatic step();
    int g [3];
    bit acc [3];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      g[k]   = model_grant(k);
      acc[k] = !m_vld[k] || rdy_in[k];
      check($sformatf("ready%0d", k), get_rout(k),
            (rst || !acc[k] || g[k] < 0) ? 32'd0 : (32'd1 << g[k]));
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      for (int k = 0; k < 3; k++) begin
        if (acc[k] && g[k] >= 0) begin
          m_vld[k]  = 1'b1;
          m_data[k] = din[k][g[k]*32 +: 32];
          m_sel[k]  = g[k];
          if (LOCK_EN && lock_in) begin
            m_lock[k] = 1'b1;
            m_lch[k]  = g[k];
          end else begin
            m_lock[k] = 1'b0;
            m_ptr[k]  = (g[k] + 1) % M_N[k];
          end
        end else if (acc[k]) begin
          m_vld[k] = 1'b0;
        end
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("valid%0d", k), get_vout(k), {31'd0, m_vld[k]});
      check($sformatf("data%0d", k),  get_dout(k), m_data[k]);
      check($sformatf("sel%0d", k),   get_sout(k), m_sel[k]);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < 3; k++) din[k] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    lock_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 4'hF;
      rdy_in[k] = 1'b1;
    end
    rand_data();

    // Reset with every channel requesting.
    step();
    step();
    check("rst_ready", {28'd0, rout0}, 32'd0);
    check("rst_valid", {31'd0, vout0}, 32'd0);
    rst = 1'b0;

    // Fairness: all channels valid, no backpressure.
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step();
      check("rr4_seq", {30'd0, sout0}, i % 4);
      check("rr3_seq", {30'd0, sout2}, i % 3);
      check("fp_seq",  {30'd0, sout1}, 32'd0);
    end

    // Backpressure holds channel 2's word, then channel 3 follows.
    vin[0] = 4'b0100;
    din[0][64 +: 32] = 32'hDEADBEEF;
    step();
    check("bp_data", dout0, 32'hDEADBEEF);
    vin[0] = 4'hF;
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", dout0, 32'hDEADBEEF);
      check("bp_sel", {30'd0, sout0}, 32'd2);
      check("bp_ready", {28'd0, rout0}, 32'd0);
    end
    rdy_in[0] = 1'b1;
    step();
    check("bp_next", {30'd0, sout0}, 32'd3);

    // Fixed priority: channel 1 beats channel 3 every cycle.
    vin[1] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_win", {30'd0, sout1}, 32'd1);
    end

    // Three-channel wrap: channel 2 then channel 0 with no gap.
    vin[2] = 4'b0100;
    step();
    vin[2] = 4'b0001;
    step();
    check("wrap_sel", {30'd0, sout2}, 32'd0);
    check("wrap_valid", {31'd0, vout2}, 32'd1);

    // Drain and refill back to back, then drain to idle.
    vin[0] = 4'b0001;
    din[0][0 +: 32] = 32'h11;
    step();
    check("dr_d0", dout0, 32'h11);
    vin[0] = 4'b0010;
    din[0][32 +: 32] = 32'h22;
    step();
    check("dr_d1", dout0, 32'h22);
    check("dr_v1", {31'd0, vout0}, 32'd1);
    vin[0] = 4'b0000;
    step();
    check("dr_idle", {31'd0, vout0}, 32'd0);
    check("dr_keep", dout0, 32'h22);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rand_data();
      for (int k = 0; k < 3; k++) begin
        vin[k] = 4'($urandom);
        rdy_in[k] = ($urandom_range(3) != 0);
      end
      rst = ($urandom_range(39) == 0);
      lock_in = LOCK_EN && ($urandom_range(3) == 0);
      step();
    end

`ifdef GEN_MUX_LOCK_EN
    // Lock onto channel 1 while neighbours compete, then release to channel 2.
    rst = 1'b1;
    lock_in = 1'b0;
    for (int k = 0; k < 3; k++) rdy_in[k] = 1'b1;
    step();
    rst = 1'b0;
    vin[0] = 4'b0010;
    lock_in = 1'b1;
    step();
    vin[0] = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lock_sel", {30'd0, sout0}, 32'd1);
    end
    lock_in = 1'b0;
    step();
    check("unlock_sel", {30'd0, sout0}, 32'd1);
    step();
    check("after_unlock", {30'd0, sout0}, 32'd2);
`endif

    rst = 1'b0;
    lock_in = 1'b0;
    for (int k = 0; k < 3; k++) vin[k] = 4'h0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
